// File: rtl/block_accum_if.sv
// block_accum_if: tile request, status and
// result read-port bundle for block_accum.
interface block_accum_if #(
  parameter int DATA_W = 32,
  parameter int TILE_R = 2,
  parameter int TILE_C = 2,
  parameter int MAT_R  = 4,
  parameter int MAT_C  = 4
);
  localparam int AW = $clog2(MAT_R * MAT_C);

  logic                             start;
  logic [1:0]                       mode;
  logic [9:0]                       start_row;
  logic [9:0]                       start_col;
  logic [TILE_R*TILE_C*DATA_W-1:0]  blk_data;
  logic                             busy;
  logic                             done;
  logic                             oob;
  logic [AW-1:0]                    rd_addr;
  logic [DATA_W-1:0]                rd_data;

  modport master (
    output start, mode, start_row, start_col,
    output blk_data, rd_addr,
    input  busy, done, oob, rd_data
  );

  modport slave (
    input  start, mode, start_row, start_col,
    input  blk_data, rd_addr,
    output busy, done, oob, rd_data
  );
endinterface

// File: rtl/block_accum.sv
// block_accum: folds a TILE_R x TILE_C block into an
// internal row-major result matrix, LANES words per cycle.

module fadd (
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic [31:0] result
);
  function automatic logic [31:0] add(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [31:0]       x, y;
    logic [7:0]        d;
    logic [26:0]       ax, ay, ty, n;
    logic [27:0]       s;
    logic [4:0]        lz;
    logic              hit, ru;
    logic [24:0]       r;
    logic signed [9:0] e;
    if (a[30:23] == 8'hff || b[30:23] == 8'hff) begin
      if ((a[30:23] == 8'hff && a[22:0] != '0) ||
          (b[30:23] == 8'hff && b[22:0] != '0))
        return 32'h7fc0_0000;
      if (a[30:23] == 8'hff && b[30:23] == 8'hff &&
          a[31] != b[31])
        return 32'h7fc0_0000;
      return (a[30:23] == 8'hff) ? a : b;
    end
    // denormal inputs are flushed to zero
    if (a[30:23] == '0 && b[30:23] == '0)
      return {a[31] & b[31], 31'b0};
    if (a[30:23] == '0) return b;
    if (b[30:23] == '0) return a;
    if (a[30:0] >= b[30:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    d  = x[30:23] - y[30:23];
    ax = {1'b1, x[22:0], 3'b000};
    ty = {1'b1, y[22:0], 3'b000};
    if (d >= 8'd27) begin
      ay = 27'd1;
    end else begin
      ay = ty >> d;
      if ((ay << d) != ty) ay[0] = 1'b1;
    end
    if (x[31] ^ y[31])
      s = {1'b0, ax} - {1'b0, ay};
    else
      s = {1'b0, ax} + {1'b0, ay};
    if (s == '0) return 32'h0;
    e = $signed({2'b00, x[30:23]});
    if (s[27]) begin
      n    = s[27:1];
      n[0] = n[0] | s[0];
      e    = e + 10'sd1;
    end else begin
      lz  = '0;
      hit = 1'b0;
      for (int i = 26; i >= 0; i--) begin
        if (!hit) begin
          if (s[i]) hit = 1'b1;
          else      lz  = lz + 5'd1;
        end
      end
      n = s[26:0] << lz;
      e = e - $signed({5'b0, lz});
    end
    ru = n[2] & (n[3] | n[1] | n[0]);
    r  = {1'b0, n[26:3]} + {24'b0, ru};
    if (r[24]) begin
      r = r >> 1;
      e = e + 10'sd1;
    end
    if (e >= 10'sd255) return {x[31], 8'hff, 23'b0};
    if (e <= 10'sd0)   return {x[31], 31'b0};
    return {x[31], e[7:0], r[22:0]};
  endfunction

  // single-precision add, round to nearest even
  always_comb result = add(a_in, b_in);
endmodule

module block_accum #(
  parameter int DATA_W = 32,
  parameter int TILE_R = 2,
  parameter int TILE_C = 2,
  parameter int MAT_R  = 4,
  parameter int MAT_C  = 4,
  parameter int LANES  = 1
) (
  input logic          clk,
  input logic          rst,
  block_accum_if.slave bus
);
  localparam int N     = TILE_R * TILE_C;
  localparam int BEATS = N / LANES;
  localparam int DEPTH = MAT_R * MAT_C;
  localparam int AW    = $clog2(DEPTH);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef struct packed {
    logic [1:0]          mode;
    logic [9:0]          row;
    logic [9:0]          col;
    logic [N*DATA_W-1:0] blk;
  } op_t;

  state_t                        state_q, state_d;
  op_t                           op_q;
  logic [BW-1:0]                 beat_q;
  logic                          oob_q;
  logic [DATA_W-1:0]             mem [DEPTH];
  logic                          accept, last;
  logic                          is_ovw, is_clr;
  logic [LANES-1:0]              lane_inb;
  logic [LANES-1:0][AW-1:0]      lane_addr;
  logic [LANES-1:0][DATA_W-1:0]  lane_old;
  logic [LANES-1:0][DATA_W-1:0]  lane_elem;
  logic [LANES-1:0][DATA_W-1:0]  lane_sum;
  logic [LANES-1:0][DATA_W-1:0]  lane_wval;

  assign accept = (state_q == IDLE) && bus.start;
  assign last   = (beat_q == BW'(BEATS - 1));
  assign is_ovw = (op_q.mode == 2'b01);
  assign is_clr = (op_q.mode == 2'b10);

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // next state: one pass over the tile, then a done cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // operation capture, beat counter and sticky out-of-bounds flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q   <= '0;
      beat_q <= '0;
      oob_q  <= 1'b0;
    end else if (accept) begin
      op_q   <= '{mode: bus.mode,
                  row:  bus.start_row,
                  col:  bus.start_col,
                  blk:  bus.blk_data};
      beat_q <= '0;
      oob_q  <= 1'b0;
    end else if (state_q == RUN) begin
      beat_q <= beat_q + BW'(1);
      oob_q  <= oob_q | ~&lane_inb;
    end
  end

  // per-lane element, target address and current buffer word
  always_comb begin
    int         e;
    logic [10:0] tr, tc;
    lane_inb  = '0;
    lane_addr = '0;
    lane_old  = '0;
    lane_elem = '0;
    for (int l = 0; l < LANES; l++) begin
      e  = int'(beat_q) * LANES + l;
      tr = {1'b0, op_q.row} + 11'(e / TILE_C);
      tc = {1'b0, op_q.col} + 11'(e % TILE_C);
      lane_inb[l]  = (tr < 11'(MAT_R)) && (tc < 11'(MAT_C));
      lane_addr[l] = AW'(int'(tr) * MAT_C + int'(tc));
      lane_elem[l] = op_q.blk[e*DATA_W +: DATA_W];
      lane_old[l]  = lane_inb[l] ? mem[lane_addr[l]] : '0;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    if (DATA_W == 32) begin : g_fp
      fadd u_fadd (
        .a_in   (lane_old[l]),
        .b_in   (lane_elem[l]),
        .result (lane_sum[l])
      );
    end else begin : g_int
      assign lane_sum[l] = lane_old[l] + lane_elem[l];
    end
  end

  // write value by mode; reserved mode accumulates
  always_comb begin
    lane_wval = '0;
    for (int l = 0; l < LANES; l++) begin
      unique case (1'b1)
        is_clr:  lane_wval[l] = '0;
        is_ovw:  lane_wval[l] = lane_elem[l];
        default: lane_wval[l] = lane_sum[l];
      endcase
    end
  end

  // result buffer: in-bounds lane writes during RUN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state_q == RUN) begin
      for (int l = 0; l < LANES; l++)
        if (lane_inb[l]) mem[lane_addr[l]] <= lane_wval[l];
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.oob  = oob_q;
  assign bus.rd_data =
    ({1'b0, bus.rd_addr} < (AW+1)'(DEPTH)) ?
    mem[bus.rd_addr] : '0;
endmodule

// File: tb/tb_block_accum.sv
// tb_block_accum: LANES=1 and LANES=2 instances driven
// in parallel, checked against a real-arithmetic model.
module tb_block_accum;
  localparam int DW = 32;
  localparam int TR = 2;
  localparam int TC = 2;
  localparam int MR = 4;
  localparam int MC = 4;
  localparam int NE = TR * TC;
  localparam int DEPTH = MR * MC;

  localparam logic [31:0] F1  = 32'h3F80_0000;
  localparam logic [31:0] F2  = 32'h4000_0000;
  localparam logic [31:0] F3  = 32'h4040_0000;
  localparam logic [31:0] F4  = 32'h4080_0000;
  localparam logic [31:0] F5  = 32'h40A0_0000;
  localparam logic [31:0] F6  = 32'h40C0_0000;
  localparam logic [31:0] F7  = 32'h40E0_0000;
  localparam logic [31:0] F8  = 32'h4100_0000;
  localparam logic [31:0] F9  = 32'h4110_0000;
  localparam logic [31:0] F10 = 32'h4120_0000;
  localparam logic [31:0] F11 = 32'h4130_0000;
  localparam logic [31:0] FH  = 32'h3F00_0000;
  localparam logic [31:0] F15 = 32'h3FC0_0000;
  localparam logic [31:0] F25 = 32'h4020_0000;
  localparam logic [31:0] FM1 = 32'hBF80_0000;
  localparam logic [31:0] FM2 = 32'hC000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  block_accum_if #(.DATA_W(DW), .TILE_R(TR), .TILE_C(TC),
                   .MAT_R(MR), .MAT_C(MC)) bus1 ();
  block_accum_if #(.DATA_W(DW), .TILE_R(TR), .TILE_C(TC),
                   .MAT_R(MR), .MAT_C(MC)) bus2 ();

  block_accum #(.DATA_W(DW), .TILE_R(TR), .TILE_C(TC),
                .MAT_R(MR), .MAT_C(MC), .LANES(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );
  block_accum #(.DATA_W(DW), .TILE_R(TR), .TILE_C(TC),
                .MAT_R(MR), .MAT_C(MC), .LANES(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int dcnt1 = 0;
  int dcnt2 = 0;
  logic [31:0] model [DEPTH];

  typedef struct {
    logic [1:0]       mode;
    logic [9:0]       row;
    logic [9:0]       col;
    logic [127:0]     blk;
    logic             oob;
    logic [3:0][7:0]  a;
    logic [3:0][31:0] v;
  } vec_t;

  vec_t vecs [10];

  always @(negedge clk) begin
    if (bus1.done) dcnt1++;
    if (bus2.done) dcnt2++;
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic real f2r(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:23] == 8'd0) return 0.0;
    d = {x[31], 11'(int'(x[30:23]) + 896), x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real v);
    logic [63:0] d;
    logic [30:0] m;
    int e;
    logic g, st;
    d = $realtobits(v);
    if (d[62:0] == '0) return {d[63], 31'd0};
    e  = int'(d[62:52]) - 896;
    m  = {8'(e), d[51:29]};
    g  = d[28];
    st = |d[27:0];
    m  = m + 31'(g & (st | m[0]));
    return {d[63], m};
  endfunction

  function automatic logic [31:0] ref_add(input logic [31:0] a,
                                          input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  function automatic logic model_op(input logic [1:0] m,
                                    input int r, input int c,
                                    input logic [127:0] blk);
    logic o;
    int tr, tc, a;
    logic [31:0] v;
    o = 1'b0;
    for (int e = 0; e < NE; e++) begin
      tr = r + e / TC;
      tc = c + e % TC;
      v  = blk[e*32 +: 32];
      if (tr >= MR || tc >= MC) begin
        o = 1'b1;
      end else begin
        a = tr * MC + tc;
        case (m)
          2'b01:   model[a] = v;
          2'b10:   model[a] = '0;
          default: model[a] = ref_add(model[a], v);
        endcase
      end
    end
    return o;
  endfunction

  function automatic vec_t mk(
    input logic [1:0] m, input int r, input int c,
    input logic [31:0] b0, b1, b2, b3, input logic o,
    input int a0, a1, a2, a3,
    input logic [31:0] v0, v1, v2, v3);
    vec_t t;
    t.mode = m;
    t.row  = 10'(r);
    t.col  = 10'(c);
    t.blk  = {b3, b2, b1, b0};
    t.oob  = o;
    t.a    = {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    t.v    = {v3, v2, v1, v0};
    return t;
  endfunction

  function automatic logic [31:0] rnd_f();
    logic [31:0] x;
    x = $urandom;
    x[30:23] = 8'(124 + $urandom_range(0, 6));
    return x;
  endfunction

  task automatic drive(input logic s, input logic [1:0] m,
                       input logic [9:0] r, input logic [9:0] c,
                       input logic [127:0] blk);
    bus1.start = s;  bus2.start = s;
    bus1.mode = m;   bus2.mode = m;
    bus1.start_row = r; bus2.start_row = r;
    bus1.start_col = c; bus2.start_col = c;
    bus1.blk_data = blk; bus2.blk_data = blk;
  endtask

  task automatic compare_buf(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      bus1.rd_addr = 4'(a);
      bus2.rd_addr = 4'(a);
      #1;
      check($sformatf("%s l1 rd[%0d]", tag, a), bus1.rd_data, model[a]);
      check($sformatf("%s l2 rd[%0d]", tag, a), bus2.rd_data, model[a]);
    end
  endtask

  task automatic read_one(input string tag, input int a,
                          input logic [31:0] exp);
    bus1.rd_addr = 4'(a);
    bus2.rd_addr = 4'(a);
    #1;
    check($sformatf("%s l1 vec[%0d]", tag, a), bus1.rd_data, exp);
    check($sformatf("%s l2 vec[%0d]", tag, a), bus2.rd_data, exp);
  endtask

  task automatic run_op(input logic [1:0] m, input logic [9:0] r,
                        input logic [9:0] c, input logic [127:0] blk,
                        input string tag);
    int b1, b2, t1, t2, d1, d2;
    logic o_exp;
    b1 = 0; b2 = 0; t1 = 0; t2 = 0;
    @(negedge clk);
    drive(1'b1, m, r, c, blk);
    d1 = dcnt1;
    d2 = dcnt2;
    @(posedge clk);
    #1;
    drive(1'b0, ~m, 10'($urandom), 10'($urandom),
          {$urandom, $urandom, $urandom, $urandom});
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus1.busy) b1++;
      if (bus2.busy) b2++;
      if (bus1.done && t1 == 0) t1 = k;
      if (bus2.done && t2 == 0) t2 = k;
    end
    o_exp = model_op(m, int'(r), int'(c), blk);
    check({tag, " l1 busy cycles"}, b1, 4);
    check({tag, " l2 busy cycles"}, b2, 2);
    check({tag, " l1 done cycle"}, t1, 5);
    check({tag, " l2 done cycle"}, t2, 3);
    check({tag, " l1 done count"}, dcnt1 - d1, 1);
    check({tag, " l2 done count"}, dcnt2 - d2, 1);
    check({tag, " l1 oob"}, bus1.oob, o_exp);
    check({tag, " l2 oob"}, bus2.oob, o_exp);
    compare_buf(tag);
  endtask

  initial begin
    int d1, d2;
    logic [127:0] ones;
    logic [127:0] rb;
    ones = {F1, F1, F1, F1};

    vecs[0] = mk(2'b00, 0, 0, F1, F2, F3, F1, 1'b0,
                 0, 1, 4, 5, F1, F2, F3, F1);
    vecs[1] = mk(2'b00, 0, 0, F1, F2, F3, F1, 1'b0,
                 0, 1, 4, 5, F2, F4, F6, F2);
    vecs[2] = mk(2'b01, 3, 3, F1, F1, F1, F1, 1'b1,
                 15, 14, 11, 0, F1, 0, 0, F2);
    vecs[3] = mk(2'b00, 1, 2, FH, F15, F25, FM1, 1'b0,
                 6, 7, 10, 11, FH, F15, F25, FM1);
    vecs[4] = mk(2'b00, 1, 2, FH, F15, F25, FM1, 1'b0,
                 6, 7, 10, 11, F1, F3, F5, FM2);
    vecs[5] = mk(2'b10, 1, 2, F1, F1, F1, F1, 1'b0,
                 6, 7, 10, 11, 0, 0, 0, 0);
    vecs[6] = mk(2'b11, 0, 0, F1, F1, F1, F1, 1'b0,
                 0, 1, 4, 5, F3, F5, F7, F3);
    vecs[7] = mk(2'b00, 4, 0, F1, F1, F1, F1, 1'b1,
                 0, 1, 4, 5, F3, F5, F7, F3);
    vecs[8] = mk(2'b01, 0, 3, F8, F9, F10, F11, 1'b1,
                 3, 7, 2, 15, F8, F10, 0, F1);
    vecs[9] = mk(2'b00, 1023, 0, F1, F1, F1, F1, 1'b1,
                 0, 1, 2, 3, F3, F5, 0, F8);

    for (int a = 0; a < DEPTH; a++) model[a] = '0;
    rst = 1'b0;
    drive(1'b0, 2'b00, '0, '0, '0);
    bus1.rd_addr = '0;
    bus2.rd_addr = '0;
    repeat (2) @(negedge clk);
    check("reset l1 busy", bus1.busy, 0);
    check("reset l2 busy", bus2.busy, 0);
    check("reset l1 done", bus1.done, 0);
    check("reset l1 oob", bus1.oob, 0);
    compare_buf("reset");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].mode, vecs[i].row, vecs[i].col,
             vecs[i].blk, $sformatf("vec%0d", i));
      check($sformatf("vec%0d l1 oob tbl", i), bus1.oob, vecs[i].oob);
      check($sformatf("vec%0d l2 oob tbl", i), bus2.oob, vecs[i].oob);
      for (int k = 0; k < 4; k++)
        read_one($sformatf("vec%0d", i), int'(vecs[i].a[k]),
                 vecs[i].v[k]);
    end

    for (int i = 0; i < 30; i++) begin
      rb = {rnd_f(), rnd_f(), rnd_f(), rnd_f()};
      run_op(2'($urandom_range(0, 3)),
             10'($urandom_range(0, 5)),
             10'($urandom_range(0, 5)),
             rb, $sformatf("rnd%0d", i));
    end

    // start held/toggled during RUN: only the first is taken
    d1 = dcnt1;
    d2 = dcnt2;
    @(negedge clk);
    drive(1'b1, 2'b00, 10'd0, 10'd0, ones);
    @(negedge clk);
    bus1.start = 1'b1; bus2.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0; bus2.start = 1'b0;
    @(negedge clk);
    bus1.start = 1'b1; bus2.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0; bus2.start = 1'b0;
    repeat (8) @(negedge clk);
    void'(model_op(2'b00, 0, 0, ones));
    check("hold l1 done count", dcnt1 - d1, 1);
    check("hold l2 done count", dcnt2 - d2, 1);
    compare_buf("hold");

    // reset in the middle of RUN
    d1 = dcnt1;
    d2 = dcnt2;
    @(negedge clk);
    drive(1'b1, 2'b00, 10'd0, 10'd0, ones);
    @(posedge clk);
    #1;
    bus1.start = 1'b0; bus2.start = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    for (int a = 0; a < DEPTH; a++) model[a] = '0;
    check("midrst l1 busy", bus1.busy, 0);
    check("midrst l2 busy", bus2.busy, 0);
    check("midrst l1 done", bus1.done, 0);
    check("midrst l1 oob", bus1.oob, 0);
    compare_buf("midrst");
    @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    check("midrst l1 no done", dcnt1 - d1, 0);
    check("midrst l2 no done", dcnt2 - d2, 0);
    check("midrst l1 idle", bus1.busy, 0);

    // start on the first edge after reset release
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    d1 = dcnt1;
    d2 = dcnt2;
    drive(1'b1, 2'b00, 10'd0, 10'd0, {F1, F3, F2, F1});
    @(posedge clk);
    #1;
    bus1.start = 1'b0; bus2.start = 1'b0;
    check("first l1 busy", bus1.busy, 1);
    check("first l2 busy", bus2.busy, 1);
    repeat (8) @(negedge clk);
    void'(model_op(2'b00, 0, 0, {F1, F3, F2, F1}));
    check("first l1 done count", dcnt1 - d1, 1);
    check("first l2 done count", dcnt2 - d2, 1);
    compare_buf("first");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
